// File: rtl/mem_byte_arbiter_if.sv
// Bus bundle between mem_byte_arbiter, its two requesters (IF, MEM) and the byte-wide RAM.
// slave = arbiter side, master = requester/RAM side.
interface mem_byte_arbiter_if #(
  parameter int unsigned MADDR_SZ = 32
);
  logic                if_req;
  logic [MADDR_SZ-1:0] if_addr;
  logic [63:0]         if_rdata;
  logic                if_ack;
  logic                mem_req;
  logic                mem_we;
  logic [1:0]          mem_size;
  logic [MADDR_SZ-1:0] mem_addr;
  logic [63:0]         mem_wdata;
  logic [63:0]         mem_rdata;
  logic                mem_ack;
  logic [MADDR_SZ-1:0] ram_addr;
  logic [7:0]          ram_din;
  logic                ram_we;
  logic [7:0]          ram_dout;
  logic                busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_dout,
    output if_rdata, if_ack, mem_rdata, mem_ack, ram_addr, ram_din, ram_we, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_dout,
    input  if_rdata, if_ack, mem_rdata, mem_ack, ram_addr, ram_din, ram_we, busy
  );
endinterface

// File: rtl/mem_byte_arbiter.sv
// Shares a byte-wide RAM between IF and MEM ports, splitting requests into big-endian byte
// accesses. Define ROUND_ROBIN_EN for alternating tie-break instead of fixed MEM priority.
module mem_byte_arbiter #(
  parameter int unsigned MADDR_SZ = 32,
  parameter int unsigned IF_BYTES = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_byte_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRd, StWset, StWpul, StAck} state_e;

  localparam logic [3:0] IfN = 4'(IF_BYTES);
  localparam logic [MADDR_SZ-1:0] AddrOne = {{(MADDR_SZ-1){1'b0}}, 1'b1};

  state_e              r_state;
  logic [MADDR_SZ-1:0] r_ram_addr;
  logic [7:0]          r_ram_din;
  logic                r_ram_we;
  logic [63:0]         r_acc;
  logic [63:0]         r_wdata;
  logic [63:0]         r_if_rdata;
  logic [63:0]         r_mem_rdata;
  logic                r_if_ack;
  logic                r_mem_ack;
  logic                r_busy;
  logic                r_sel_mem;
  logic [3:0]          r_n;
  logic [3:0]          r_cnt;
`ifdef ROUND_ROBIN_EN
  logic                r_last_mem;
`endif

  logic        w_grant_mem;
  logic [3:0]  w_mem_n;
  logic [5:0]  w_sh;
  logic [63:0] w_align;
  logic        w_last;
  logic [63:0] w_acc_nxt;

  always_comb begin
`ifdef ROUND_ROBIN_EN
    w_grant_mem = bus.mem_req & (~bus.if_req | ~r_last_mem);
`else
    w_grant_mem = bus.mem_req;
`endif
    w_mem_n   = 4'd1 << bus.mem_size;
    // Left-align the N store bytes so the next byte to write is always [63:56].
    w_sh      = {3'(4'd8 - w_mem_n), 3'b000};
    w_align   = bus.mem_wdata << w_sh;
    w_last    = (r_cnt == (r_n - 4'd1));
    w_acc_nxt = {r_acc[55:0], bus.ram_dout};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_ram_we    <= 1'b0;
      r_acc       <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_busy      <= 1'b0;
      r_sel_mem   <= 1'b0;
      r_n         <= '0;
      r_cnt       <= '0;
`ifdef ROUND_ROBIN_EN
      r_last_mem  <= 1'b0;
`endif
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      r_ram_we  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_mem) begin
            r_sel_mem  <= 1'b1;
            r_n        <= w_mem_n;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ram_addr <= bus.mem_addr;
            r_busy     <= 1'b1;
`ifdef ROUND_ROBIN_EN
            r_last_mem <= 1'b1;
`endif
            if (bus.mem_we) begin
              r_ram_din <= w_align[63:56];
              r_wdata   <= w_align << 8;
              r_state   <= StWset;
            end else begin
              r_state   <= StRd;
            end
          end else if (bus.if_req) begin
            r_sel_mem  <= 1'b0;
            r_n        <= IfN;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ram_addr <= bus.if_addr;
            r_busy     <= 1'b1;
`ifdef ROUND_ROBIN_EN
            r_last_mem <= 1'b0;
`endif
            r_state    <= StRd;
          end
        end
        StRd: begin
          r_acc      <= w_acc_nxt;
          r_cnt      <= r_cnt + 4'd1;
          r_ram_addr <= r_ram_addr + AddrOne;
          if (w_last) begin
            r_state <= StAck;
            if (r_sel_mem) begin
              r_mem_rdata <= w_acc_nxt;
              r_mem_ack   <= 1'b1;
            end else begin
              r_if_rdata <= w_acc_nxt;
              r_if_ack   <= 1'b1;
            end
          end
        end
        StWset: begin
          r_ram_we <= 1'b1;
          r_state  <= StWpul;
        end
        StWpul: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_mem_ack <= 1'b1;
            r_state   <= StAck;
          end else begin
            r_ram_addr <= r_ram_addr + AddrOne;
            r_ram_din  <= r_wdata[63:56];
            r_wdata    <= r_wdata << 8;
            r_state    <= StWset;
          end
        end
        StAck: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ack   = r_mem_ack;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_din   = r_ram_din;
  assign bus.ram_we    = r_ram_we;
  assign bus.busy      = r_busy;

endmodule
